// File: rtl/noc_packet_tx.sv
// NoC packet transmitter: emits a header word followed by tx_len payload words
// on an AXI4-Stream master, with registered outputs and transmit statistics.
module noc_packet_tx #(
    parameter int BW    = 32,
    parameter int XY_SZ = 3,
    parameter int LEN_W = 8
) (
    input  logic             clk_line,
    input  logic             clk_line_rst_low,
    input  logic [BW-1:0]    tile_coordinates_line,
    input  logic             tx_start,
    input  logic [XY_SZ-1:0] tx_dest_x,
    input  logic [XY_SZ-1:0] tx_dest_y,
    input  logic [LEN_W-1:0] tx_len,
    output logic             tx_busy,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [BW-1:0]    pl_data,
    output logic [BW-1:0]    stream_in_TDATA,
    output logic             stream_in_TVALID,
    output logic             stream_in_TLAST,
    input  logic             stream_in_TREADY,
    input  logic             tx_cnt_clr,
    output logic [BW-1:0]    txPacketCount,
    output logic [BW-1:0]    txByteCount
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] remaining;
    logic             start, load, beat;
    logic             unused_tile;

    assign unused_tile = ^tile_coordinates_line[BW-1:8];

    function automatic logic [BW-1:0] build_header(
        input logic [XY_SZ-1:0] dx,
        input logic [XY_SZ-1:0] dy,
        input logic [7:0]       src,
        input logic [LEN_W-1:0] len
    );
        logic [BW-1:0] h;
        h = '0;
        h[XY_SZ-1:0]       = dx;
        h[2*XY_SZ-1:XY_SZ] = dy;
        h[15:8]            = src;
        h[16+LEN_W-1:16]   = len;
        return h;
    endfunction

    assign start = (state == IDLE) && tx_start;
    assign load  = pl_valid && pl_ready;
    assign beat  = stream_in_TVALID && stream_in_TREADY;

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) state <= IDLE;
        else                   state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_busy   = 1'b0;
        pl_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (tx_start) state_nxt = SEND;
            end
            SEND: begin
                tx_busy  = 1'b1;
                pl_ready = (remaining != '0) && (!stream_in_TVALID || stream_in_TREADY);
                if (beat && stream_in_TLAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output stream registers: a new load always wins over retiring the current beat.
    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            stream_in_TDATA  <= '0;
            stream_in_TVALID <= 1'b0;
            stream_in_TLAST  <= 1'b0;
            remaining        <= '0;
        end else if (start) begin
            stream_in_TDATA  <= build_header(tx_dest_x, tx_dest_y,
                                             tile_coordinates_line[7:0], tx_len);
            stream_in_TVALID <= 1'b1;
            stream_in_TLAST  <= (tx_len == '0);
            remaining        <= tx_len;
        end else if (load) begin
            stream_in_TDATA  <= pl_data;
            stream_in_TVALID <= 1'b1;
            stream_in_TLAST  <= (remaining == LEN_W'(1));
            remaining        <= remaining - LEN_W'(1);
        end else if (beat) begin
            stream_in_TVALID <= 1'b0;
        end
    end

    always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
        if (!clk_line_rst_low) begin
            txPacketCount <= '0;
            txByteCount   <= '0;
        end else if (tx_cnt_clr) begin
            txPacketCount <= '0;
            txByteCount   <= '0;
        end else if (beat) begin
            txByteCount   <= txByteCount + BW'(4);
            txPacketCount <= txPacketCount + {{(BW-1){1'b0}}, stream_in_TLAST};
        end
    end

endmodule

// File: tb/tb_noc_packet_tx.sv
// Directed bench for noc_packet_tx: header format, streaming, backpressure,
// busy-start rejection, counter wrap/clear and mid-packet reset.
module tb_noc_packet_tx;

    localparam int BW = 32, XY_SZ = 3, LEN_W = 8;

    logic             clk_line = 1'b0;
    logic             clk_line_rst_low;
    logic [BW-1:0]    tile_coordinates_line;
    logic             tx_start;
    logic [XY_SZ-1:0] tx_dest_x, tx_dest_y;
    logic [LEN_W-1:0] tx_len;
    logic             tx_busy;
    logic             pl_valid, pl_ready;
    logic [BW-1:0]    pl_data;
    logic [BW-1:0]    stream_in_TDATA;
    logic             stream_in_TVALID, stream_in_TLAST, stream_in_TREADY;
    logic             tx_cnt_clr;
    logic [BW-1:0]    txPacketCount, txByteCount;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [31:0] payload [16];
    int          pidx = 0;
    logic [31:0] got_data [$];
    logic        got_last [$];

    always #5 clk_line = ~clk_line;

    assign pl_data = payload[pidx];

    noc_packet_tx #(.BW(BW), .XY_SZ(XY_SZ), .LEN_W(LEN_W)) dut (
        .clk_line(clk_line), .clk_line_rst_low(clk_line_rst_low),
        .tile_coordinates_line(tile_coordinates_line),
        .tx_start(tx_start), .tx_dest_x(tx_dest_x), .tx_dest_y(tx_dest_y),
        .tx_len(tx_len), .tx_busy(tx_busy),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .stream_in_TDATA(stream_in_TDATA), .stream_in_TVALID(stream_in_TVALID),
        .stream_in_TLAST(stream_in_TLAST), .stream_in_TREADY(stream_in_TREADY),
        .tx_cnt_clr(tx_cnt_clr),
        .txPacketCount(txPacketCount), .txByteCount(txByteCount)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Records each beat that will complete on the coming rising edge and
    // advances the payload pointer after each accepted payload word.
    initial begin
        logic adv;
        forever begin
            @(negedge clk_line); #2;
            adv = pl_valid && pl_ready;
            if (stream_in_TVALID && stream_in_TREADY) begin
                got_data.push_back(stream_in_TDATA);
                got_last.push_back(stream_in_TLAST);
            end
            @(posedge clk_line); #1;
            if (adv) pidx++;
        end
    end

    task automatic start_pkt(input logic [2:0] x, input logic [2:0] y, input logic [7:0] len);
        tx_dest_x = x; tx_dest_y = y; tx_len = len; tx_start = 1'b1;
        @(negedge clk_line);
        tx_start = 1'b0;
    endtask

    task automatic clear_counters();
        tx_cnt_clr = 1'b1;
        @(negedge clk_line);
        tx_cnt_clr = 1'b0;
    endtask

    task automatic check_stream(input string tag, input int n, input logic [31:0] exp [6]);
        check_eq({tag, "_beats"}, got_data.size(), n);
        for (int i = 0; i < n; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i),
                     (i < got_data.size()) ? got_data[i] : 32'hDEAD_BEEF, exp[i]);
            check_eq($sformatf("%s_last%0d", tag, i),
                     (i < got_last.size()) ? 32'(got_last[i]) : 32'hDEAD_BEEF, 32'(i == n - 1));
        end
    endtask

    initial begin
        logic [31:0] exp [6];
        for (int i = 0; i < 16; i++) payload[i] = 32'hC0DE_0000 | i;
        clk_line_rst_low = 1'b0;
        tile_coordinates_line = 32'h0000_0015;
        tx_start = 1'b0; tx_dest_x = '0; tx_dest_y = '0; tx_len = '0;
        pl_valid = 1'b0; stream_in_TREADY = 1'b1; tx_cnt_clr = 1'b0;

        // Reset state
        repeat (2) @(negedge clk_line);
        check_eq("rst_tvalid", stream_in_TVALID, 0);
        check_eq("rst_tlast", stream_in_TLAST, 0);
        check_eq("rst_tdata", stream_in_TDATA, 0);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_plready", pl_ready, 0);
        check_eq("rst_pkt", txPacketCount, 0);
        check_eq("rst_byte", txByteCount, 0);
        clk_line_rst_low = 1'b1;
        @(negedge clk_line);

        // Header-only packet
        start_pkt(3, 5, 0);
        check_eq("hdr_tvalid", stream_in_TVALID, 1);
        check_eq("hdr_tdata", stream_in_TDATA, 32'h0000_152B);
        check_eq("hdr_tlast", stream_in_TLAST, 1);
        check_eq("hdr_busy", tx_busy, 1);
        @(negedge clk_line);
        check_eq("hdr_tvalid_after", stream_in_TVALID, 0);
        check_eq("hdr_busy_after", tx_busy, 0);
        check_eq("hdr_pkt", txPacketCount, 1);
        check_eq("hdr_byte", txByteCount, 4);

        // Streaming packet, len 4
        clear_counters();
        got_data.delete(); got_last.delete();
        pidx = 0; pl_valid = 1'b1;
        start_pkt(1, 2, 4);
        repeat (7) @(negedge clk_line);
        pl_valid = 1'b0;
        exp = '{32'h0004_1511, 32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 0};
        check_stream("stream", 5, exp);
        check_eq("stream_byte", txByteCount, 20);
        check_eq("stream_pkt", txPacketCount, 1);

        // Backpressure for 3 cycles while first payload word is presented
        clear_counters();
        got_data.delete(); got_last.delete();
        pidx = 4; pl_valid = 1'b1;
        start_pkt(7, 0, 4);
        @(negedge clk_line);
        for (int k = 0; k < 3; k++) begin
            stream_in_TREADY = 1'b0;
            #1;
            check_eq($sformatf("bp_tvalid%0d", k), stream_in_TVALID, 1);
            check_eq($sformatf("bp_tdata%0d", k), stream_in_TDATA, 32'hC0DE_0004);
            check_eq($sformatf("bp_tlast%0d", k), stream_in_TLAST, 0);
            check_eq($sformatf("bp_plready%0d", k), pl_ready, 0);
            @(negedge clk_line);
        end
        stream_in_TREADY = 1'b1;
        repeat (6) @(negedge clk_line);
        pl_valid = 1'b0;
        exp = '{32'h0004_1507, 32'hC0DE_0004, 32'hC0DE_0005, 32'hC0DE_0006, 32'hC0DE_0007, 0};
        check_stream("bp", 5, exp);
        check_eq("bp_byte", txByteCount, 20);

        // tx_start while busy is ignored
        clear_counters();
        got_data.delete(); got_last.delete();
        start_pkt(2, 3, 2);
        tx_start = 1'b1; tx_len = 5; tx_dest_x = 6;
        repeat (2) @(negedge clk_line);
        check_eq("busy_during", tx_busy, 1);
        tx_start = 1'b0;
        pidx = 8; pl_valid = 1'b1;
        repeat (6) @(negedge clk_line);
        pl_valid = 1'b0;
        exp = '{32'h0002_151A, 32'hC0DE_0008, 32'hC0DE_0009, 0, 0, 0};
        check_stream("busy", 3, exp);
        check_eq("busy_pkt", txPacketCount, 1);
        check_eq("busy_idle", tx_busy, 0);

        // Byte counter wrap
        force dut.txByteCount = 32'hFFFF_FFFC;
        #1 release dut.txByteCount;
        start_pkt(0, 0, 0);
        @(negedge clk_line);
        check_eq("wrap_byte", txByteCount, 0);
        check_eq("wrap_pkt", txPacketCount, 2);

        // Clear in the same cycle as a TLAST beat
        start_pkt(0, 0, 0);
        tx_cnt_clr = 1'b1;
        @(negedge clk_line);
        tx_cnt_clr = 1'b0;
        check_eq("clr_byte", txByteCount, 0);
        check_eq("clr_pkt", txPacketCount, 0);

        // Reset after two of four payload beats
        got_data.delete(); got_last.delete();
        pidx = 10; pl_valid = 1'b1;
        start_pkt(4, 4, 4);
        repeat (3) @(negedge clk_line);
        #1 clk_line_rst_low = 1'b0;
        pl_valid = 1'b0;
        #1;
        check_eq("rstmid_tvalid", stream_in_TVALID, 0);
        check_eq("rstmid_busy", tx_busy, 0);
        check_eq("rstmid_plready", pl_ready, 0);
        check_eq("rstmid_beats", got_data.size(), 3);
        @(negedge clk_line);
        clk_line_rst_low = 1'b1;
        repeat (3) @(negedge clk_line);
        check_eq("rstmid_no_resume", stream_in_TVALID, 0);
        check_eq("rstmid_idle", tx_busy, 0);
        got_data.delete(); got_last.delete();
        pidx = 14; pl_valid = 1'b1;
        start_pkt(0, 1, 1);
        repeat (5) @(negedge clk_line);
        pl_valid = 1'b0;
        exp = '{32'h0001_1508, 32'hC0DE_000E, 0, 0, 0, 0};
        check_stream("post_rst", 2, exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/noc_packet_tx.md
NOC_PACKET_TX -- requirements
Module: noc_packet_tx

Interface
REQ-001 SHALL have parameter BW, default 32: stream data width in bits, one word per beat.
REQ-002 SHALL have parameter XY_SZ, default 3: width of each destination coordinate field.
REQ-003 SHALL have parameter LEN_W, default 8: width of the payload length field in words.
REQ-004 SHALL have port clk_line  input  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port clk_line_rst_low  input  1: reset, asynchronous and active-low.
REQ-006 SHALL have port tile_coordinates_line  input  BW: own tile id; bits [7:0] are used as the source id.
REQ-007 SHALL have port tx_start  input  1: packet request, sampled only in IDLE.
REQ-008 SHALL have port tx_dest_x  input  XY_SZ: destination X coordinate.
REQ-009 SHALL have port tx_dest_y  input  XY_SZ: destination Y coordinate.
REQ-010 SHALL have port tx_len  input  LEN_W: payload word count; 0 means a header-only packet.
REQ-011 SHALL have port tx_busy  output  1: high while a packet is in progress (state SEND).
REQ-012 SHALL have ports pl_valid/pl_ready  input/output  1: payload source handshake.
REQ-013 SHALL have port pl_data  input  BW: payload word.
REQ-014 SHALL have ports stream_in_TDATA  output  BW, stream_in_TVALID  output  1, stream_in_TLAST  output  1, stream_in_TREADY  input  1: AXI4-Stream master towards the NoC.
REQ-015 SHALL have port tx_cnt_clr  input  1: synchronous clear of both counters.
REQ-016 SHALL have ports txPacketCount  output  BW and txByteCount  output  BW: transmit statistics.

Function
REQ-017 SHALL implement an FSM with two states: IDLE and SEND.
REQ-018 SHALL drive stream_in_TDATA/TVALID/TLAST from registers, with no combinational path from inputs to these outputs.
REQ-019 SHALL accept tx_start=1 in IDLE as follows. On the same edge it loads the header into TDATA, sets TVALID=1, sets TLAST=(tx_len==0), latches remaining=tx_len, and moves to SEND. TVALID is therefore visible 1 cycle after the start.
REQ-020 SHALL build the header word as follows; all other bits are 0:
- [XY_SZ-1:0] = tx_dest_x
- [2*XY_SZ-1:XY_SZ] = tx_dest_y
- [15:8] = tile_coordinates_line[7:0]
- [16+LEN_W-1:16] = tx_len
REQ-021 SHALL ignore tx_start while in SEND; no queuing and no error.
REQ-022 SHALL drive pl_ready = (state==SEND) && (remaining!=0) && (!TVALID || TREADY), combinationally.
REQ-023 SHALL, on a pl_valid&&pl_ready beat, load TDATA<=pl_data, TVALID<=1, TLAST<=(remaining==1), and remaining<=remaining-1.
REQ-024 SHALL, on a TVALID&&TREADY beat with no new load that cycle, set TVALID<=0.
REQ-025 SHALL sustain a throughput of 1 beat/cycle while TREADY and pl_valid are both held high.
REQ-026 SHALL keep TDATA and TLAST stable while TVALID=1 and TREADY=0.
REQ-027 SHALL, on a TVALID&&TREADY&&TLAST beat, go to IDLE and clear TVALID. tx_start is not sampled in that same cycle. Minimum packet spacing is 2 cycles.
REQ-028 SHALL drive tx_busy=1 exactly while in SEND.
REQ-029 SHALL apply the following counter rule on every TVALID&&TREADY beat: txByteCount += 4; txPacketCount += 1 if TLAST.
REQ-030 SHALL wrap both counters modulo 2^BW.
REQ-031 SHALL give tx_cnt_clr priority over any same-cycle increment; the counters read 0 the next cycle.
REQ-032 SHALL count the header beat in txByteCount.

Reset
REQ-033 SHALL, while clk_line_rst_low=0, immediately and asynchronously force the following, regardless of any packet in progress:
- state=IDLE
- TVALID=0, TLAST=0, TDATA=0
- remaining=0
- tx_busy=0, pl_ready=0
- both counters = 0
REQ-034 SHALL NOT complete an interrupted packet after reset is released; the next packet starts only on a new tx_start.

Verification
REQ-035 Header-only packet: tile_coordinates_line=0x15, tx_start with dest_x=3, dest_y=5, len=0, TREADY=1 -> one beat, TDATA=0x0000152B, TLAST=1, txPacketCount=1, txByteCount=4, tx_busy low after the beat.
REQ-036 Streaming packet: len=4, pl_valid and TREADY held high, payload words A..D -> 5 consecutive beats: header, A, B, C, D; TLAST only on D; txByteCount=20.
REQ-037 Backpressure: TREADY=0 for 3 cycles mid-payload -> TDATA/TLAST held stable throughout, pl_ready=0, no data lost or duplicated; all 4 payload words delivered in order.
REQ-038 Busy start: tx_start pulsed during SEND -> ignored; exactly one packet emitted and txPacketCount increments by 1.
REQ-039 Counter clear and wrap: txByteCount preset to 0xFFFFFFFC -> after one beat reads 0. tx_cnt_clr asserted in the same cycle as a TLAST beat -> both counters read 0.
REQ-040 Reset mid-packet: reset asserted after 2 of 4 payload beats -> TVALID=0 immediately. After release, a new tx_start with len=1 -> exactly 2 beats.
